// File: rtl/rv_decode_stage.sv
`default_nettype none
// ============================================================================
// rv_decode_stage: elastic decode register, integer register file with
// write-through bypass, immediate extraction and in-decode branch resolution.
// Revision: 1.0
// ============================================================================
module rv_decode_stage #(
  parameter int              XLEN     = 32,
  parameter int              NUM_REGS = 32,
  parameter int              ILEN     = 32,
  parameter logic [ILEN-1:0] NOOP     = 32'h00000013,
  localparam int             RA       = $clog2(NUM_REGS)
) (
  input  logic            i_aclk,
  input  logic            i_areset_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [ILEN-1:0] i_instr,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_pc,
  output logic [6:0]      o_opcode,
  output logic [2:0]      o_funct3,
  output logic [6:0]      o_funct7,
  output logic [RA-1:0]   o_rd_addr,
  output logic [RA-1:0]   o_rs1_addr,
  output logic [RA-1:0]   o_rs2_addr,
  output logic [XLEN-1:0] o_rd1,
  output logic [XLEN-1:0] o_rd2,
  output logic [XLEN-1:0] o_imm,
  input  logic            i_wb,
  input  logic [RA-1:0]   i_wb_addr,
  input  logic [XLEN-1:0] i_wb_data,
  input  logic            i_fwd_a,
  input  logic            i_fwd_b,
  input  logic [XLEN-1:0] i_fdata_a,
  input  logic [XLEN-1:0] i_fdata_b,
  output logic            o_branch_valid,
  output logic [XLEN-1:0] o_branch_addr
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic            valid_q;
  logic [ILEN-1:0] instr_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] regs [NUM_REGS];
  logic            take_in;
  logic [31:0]     imm32;
  logic            cond;
  logic            taken;

  assign o_ready = ~valid_q | i_ready | i_flush;
  assign take_in = i_valid & o_ready & ~i_flush;

  // Flush wins over capture; an emptied stage always holds the bubble.
  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      valid_q <= 1'b0;
      instr_q <= NOOP;
      pc_q    <= '0;
    end else if (i_flush) begin
      valid_q <= 1'b0;
      instr_q <= NOOP;
    end else if (take_in) begin
      valid_q <= 1'b1;
      instr_q <= i_instr;
      pc_q    <= i_pc;
    end else if (valid_q & i_ready) begin
      valid_q <= 1'b0;
      instr_q <= NOOP;
    end
  end

  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (i_wb && (i_wb_addr != '0)) begin
      regs[i_wb_addr] <= i_wb_data;
    end
  end

  assign o_valid    = valid_q;
  assign o_pc       = pc_q;
  assign o_opcode   = instr_q[6:0];
  assign o_funct3   = instr_q[14:12];
  assign o_funct7   = instr_q[31:25];
  assign o_rd_addr  = instr_q[7 +: RA];
  assign o_rs1_addr = instr_q[15 +: RA];
  assign o_rs2_addr = instr_q[20 +: RA];

  // Forwarding beats the same-cycle write-back, which beats the array.
  always_comb begin
    o_rd1 = regs[o_rs1_addr];
    if (o_rs1_addr == '0)                          o_rd1 = '0;
    else if (i_wb && (i_wb_addr == o_rs1_addr))    o_rd1 = i_wb_data;
    if (i_fwd_a)                                   o_rd1 = i_fdata_a;
  end

  always_comb begin
    o_rd2 = regs[o_rs2_addr];
    if (o_rs2_addr == '0)                          o_rd2 = '0;
    else if (i_wb && (i_wb_addr == o_rs2_addr))    o_rd2 = i_wb_data;
    if (i_fwd_b)                                   o_rd2 = i_fdata_b;
  end

  always_comb begin
    imm32 = '0;
    case (o_opcode)
      OP_LOAD, OP_IMM, OP_JALR:
        imm32 = {{20{instr_q[31]}}, instr_q[31:20]};
      OP_STORE:
        imm32 = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
      OP_BRANCH:
        imm32 = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25],
                 instr_q[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm32 = {instr_q[31:12], 12'b0};
      OP_JAL:
        imm32 = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20],
                 instr_q[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign o_imm = {{(XLEN-31){imm32[31]}}, imm32[30:0]};

  always_comb begin
    cond = 1'b0;
    case (o_funct3)
      3'b000:  cond = (o_rd1 == o_rd2);
      3'b001:  cond = (o_rd1 != o_rd2);
      3'b100:  cond = ($signed(o_rd1) <  $signed(o_rd2));
      3'b101:  cond = ($signed(o_rd1) >= $signed(o_rd2));
      3'b110:  cond = (o_rd1 <  o_rd2);
      3'b111:  cond = (o_rd1 >= o_rd2);
      default: cond = 1'b0;
    endcase
  end

  assign taken = ((o_opcode == OP_BRANCH) & cond) | (o_opcode == OP_JAL) |
                 (o_opcode == OP_JALR);

  assign o_branch_addr = (o_opcode == OP_JALR)
                         ? ((o_rd1 + o_imm) & {{(XLEN-1){1'b1}}, 1'b0})
                         : (pc_q + o_imm);

  // Pulse only on the outgoing transfer so a stalled jump redirects once.
  assign o_branch_valid = valid_q & i_ready & ~i_flush & taken;

endmodule
`default_nettype wire

// File: tb/tb_rv_decode_stage.sv
`default_nettype none
// Self-checking bench for rv_decode_stage: directed scenarios plus random
// traffic compared against a behavioural model of the decode stage.
module tb_rv_decode_stage;
  localparam int          XLEN = 32;
  localparam int          NREG = 32;
  localparam int          ILEN = 32;
  localparam int          RA   = 5;
  localparam logic [31:0] NOOP = 32'h00000013;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0, ready_out, flush = 1'b0, valid_out, rdy = 1'b0;
  logic [ILEN-1:0] instr = '0;
  logic [XLEN-1:0] pc = '0;
  logic [XLEN-1:0] pc_out, rd1, rd2, imm, baddr;
  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [RA-1:0]   rd_a, rs1_a, rs2_a;
  logic            wb = 1'b0, fwd_a = 1'b0, fwd_b = 1'b0, bvalid;
  logic [RA-1:0]   wb_addr = '0;
  logic [XLEN-1:0] wb_data = '0, fdata_a = '0, fdata_b = '0;

  always #5 clk = ~clk;

  rv_decode_stage #(.XLEN(XLEN), .NUM_REGS(NREG), .ILEN(ILEN), .NOOP(NOOP)) dut (
    .i_aclk(clk), .i_areset_n(rst_n), .i_valid(in_valid), .o_ready(ready_out),
    .i_instr(instr), .i_pc(pc), .i_flush(flush), .o_valid(valid_out), .i_ready(rdy),
    .o_pc(pc_out), .o_opcode(opcode), .o_funct3(funct3), .o_funct7(funct7),
    .o_rd_addr(rd_a), .o_rs1_addr(rs1_a), .o_rs2_addr(rs2_a), .o_rd1(rd1), .o_rd2(rd2),
    .o_imm(imm), .i_wb(wb), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
    .i_fwd_a(fwd_a), .i_fwd_b(fwd_b), .i_fdata_a(fdata_a), .i_fdata_b(fdata_b),
    .o_branch_valid(bvalid), .o_branch_addr(baddr));

  int checks = 0, errors = 0;
  int pulses = 0;
  logic [31:0] last_baddr;

  logic        m_valid;
  logic [31:0] m_instr, m_pc;
  logic [31:0] m_regs [NREG];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] imm_of(input logic [31:0] w);
    logic signed [31:0] t;
    case (w[6:0])
      7'b0000011, 7'b0010011, 7'b1100111: begin t = w; return t >>> 20; end
      7'b0100011: begin t = {w[31:25], w[11:7], 20'b0}; return t >>> 20; end
      7'b1100011: begin t = {w[31], w[7], w[30:25], w[11:8], 20'b0}; return t >>> 19; end
      7'b0110111, 7'b0010111: return {w[31:12], 12'b0};
      7'b1101111: begin t = {w[31], w[19:12], w[20], w[30:21], 12'b0}; return t >>> 11; end
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] a, input logic f,
                                          input logic [31:0] fd);
    if (f) return fd;
    if (a == 0) return 32'd0;
    if (wb && wb_addr == a) return wb_data;
    return m_regs[a];
  endfunction

  function automatic logic is_taken(input logic [31:0] w, input logic [31:0] a,
                                    input logic [31:0] b);
    if (w[6:0] == 7'b1101111 || w[6:0] == 7'b1100111) return 1'b1;
    if (w[6:0] != 7'b1100011) return 1'b0;
    case (w[14:12])
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_instr = NOOP; m_pc = 32'd0;
    for (int i = 0; i < NREG; i++) m_regs[i] = 32'd0;
  endtask

  // One clock: compare every output at the falling edge, then advance the model.
  task automatic step();
    logic [31:0] a, b, im, tgt;
    logic        tk, exp_rdy, exp_bv;
    @(negedge clk);
    a  = operand(m_instr[19:15], fwd_a, fdata_a);
    b  = operand(m_instr[24:20], fwd_b, fdata_b);
    im = imm_of(m_instr);
    tk = is_taken(m_instr, a, b);
    tgt = (m_instr[6:0] == 7'b1100111) ? ((a + im) & ~32'd1) : (m_pc + im);
    exp_rdy = !m_valid || rdy || flush;
    exp_bv  = m_valid && rdy && !flush && tk;
    check("ready", ready_out, exp_rdy);
    check("valid", valid_out, m_valid);
    if (m_valid) check("pc", pc_out, m_pc);
    check("opcode", opcode, m_instr[6:0]);
    check("funct3", funct3, m_instr[14:12]);
    check("funct7", funct7, m_instr[31:25]);
    check("rd_addr", rd_a, m_instr[11:7]);
    check("rs1_addr", rs1_a, m_instr[19:15]);
    check("rs2_addr", rs2_a, m_instr[24:20]);
    check("rd1", rd1, a);
    check("rd2", rd2, b);
    check("imm", imm, im);
    check("branch_valid", bvalid, exp_bv);
    if (exp_bv) check("branch_addr", baddr, tgt);
    if (bvalid) begin pulses++; last_baddr = baddr; end
    @(posedge clk);
    if (wb && wb_addr != 0) m_regs[wb_addr] = wb_data;
    if (flush) begin m_valid = 1'b0; m_instr = NOOP; end
    else if (in_valid && exp_rdy) begin m_valid = 1'b1; m_instr = instr; m_pc = pc; end
    else if (m_valid && rdy) begin m_valid = 1'b0; m_instr = NOOP; end
    #1;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    in_valid = 1'b0; rdy = 1'b1; wb = 1'b1; wb_addr = a; wb_data = d;
    step();
    wb = 1'b0;
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] im, input logic [4:0] rs1,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {im, rs1, 3'b000, rd, op};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] im, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {im[12], im[10:5], rs2, rs1, f3, im[4:1], im[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 9))
      0: w[6:0] = 7'b0000011;  1: w[6:0] = 7'b0010011;
      2: w[6:0] = 7'b1100111;  3: w[6:0] = 7'b0100011;
      4: w[6:0] = 7'b1100011;  5: w[6:0] = 7'b1100011;
      6: w[6:0] = 7'b0110111;  7: w[6:0] = 7'b0010111;
      8: w[6:0] = 7'b1101111;  default: w[6:0] = 7'b0110011;
    endcase
    if ($urandom_range(0, 3) == 0) w[24:20] = w[19:15];
    return w;
  endfunction

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", valid_out, 0);
    check("rst_pc", pc_out, 0);
    check("rst_instr", {funct7, rs2_a, rs1_a, funct3, rd_a, opcode}, NOOP);
    check("rst_bvalid", bvalid, 0);
    check("rst_baddr", baddr, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // All registers read zero; a write to x0 is ignored even through the bypass.
    for (int k = 0; k < NREG; k++) begin
      in_valid = 1'b1; rdy = 1'b1; pc = 32'(k * 4);
      instr = {7'd0, 5'(k), 5'(k), 3'd0, 5'd0, 7'b0110011};
      step();
      check("reg_reset", rd1, 0);
    end
    instr = 32'h00000033; wb = 1'b1; wb_addr = 5'd0; wb_data = 32'd5;
    step();
    check("x0_bypass", rd1, 0);
    wb = 1'b0;
    step();
    check("x0_write", rd1, 0);

    // Stall with ADDI x1,x0,7 held.
    in_valid = 1'b1; rdy = 1'b1; instr = enc_i(12'd7, 5'd0, 5'd1, 7'b0010011); pc = 32'h20;
    step();
    in_valid = 1'b0; rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("stall_valid", valid_out, 1);
      check("stall_imm", imm, 7);
      check("stall_pc", pc_out, 32'h20);
    end
    rdy = 1'b1;
    step();
    check("drain_valid", valid_out, 0);

    // Write-through bypass and forwarding override.
    in_valid = 1'b1; instr = {7'd0, 5'd3, 5'd3, 3'd0, 5'd4, 7'b0110011}; pc = 32'h24;
    step();
    in_valid = 1'b0; rdy = 1'b0; wb = 1'b1; wb_addr = 5'd3; wb_data = 32'hDEAD;
    #1;
    check("bypass_rd1", rd1, 32'hDEAD);
    check("bypass_rd2", rd2, 32'hDEAD);
    fwd_a = 1'b1; fdata_a = 32'd1;
    #1;
    check("fwd_rd1", rd1, 1);
    step();
    fwd_a = 1'b0; wb = 1'b0; rdy = 1'b1;
    step();

    // BLT taken, BLTU not taken.
    write_reg(5'd5, 32'hFFFF_FFFF);
    write_reg(5'd6, 32'd1);
    in_valid = 1'b1; rdy = 1'b1; instr = enc_b(-13'sd8, 5'd6, 5'd5, 3'b100); pc = 32'h100;
    step();
    pulses = 0; in_valid = 1'b0;
    step(); step();
    check("blt_pulses", pulses, 1);
    check("blt_addr", last_baddr, 32'hF8);
    in_valid = 1'b1; instr = enc_b(-13'sd8, 5'd6, 5'd5, 3'b110);
    step();
    pulses = 0; in_valid = 1'b0;
    step(); step();
    check("bltu_pulses", pulses, 0);

    // JALR held for two stall cycles redirects exactly once.
    write_reg(5'd7, 32'h1001);
    in_valid = 1'b1; rdy = 1'b1; instr = enc_i(12'd4, 5'd7, 5'd1, 7'b1100111); pc = 32'h40;
    step();
    pulses = 0; in_valid = 1'b0; rdy = 1'b0;
    step(); step();
    check("jalr_stall_pulses", pulses, 0);
    rdy = 1'b1;
    step(); step();
    check("jalr_pulses", pulses, 1);
    check("jalr_addr", last_baddr, 32'h1004);

    // Flush while holding a taken BEQ.
    in_valid = 1'b1; rdy = 1'b1; instr = enc_b(13'd16, 5'd0, 5'd0, 3'b000); pc = 32'h200;
    step();
    pulses = 0; rdy = 1'b0; flush = 1'b1; instr = enc_i(12'd9, 5'd0, 5'd2, 7'b0010011);
    step();
    check("flush_valid", valid_out, 0);
    flush = 1'b0; in_valid = 1'b0; rdy = 1'b1;
    step();
    check("flush_pulses", pulses, 0);
    check("flush_dropped", valid_out, 0);

    // Reset while stalled on a JAL: instruction and registers are lost.
    write_reg(5'd9, 32'h1234);
    in_valid = 1'b1; instr = 32'h0100006F; pc = 32'h300;
    step();
    in_valid = 1'b0; rdy = 1'b0; pulses = 0;
    #2 rst_n = 1'b0;
    #1 model_reset();
    check("midrst_valid", valid_out, 0);
    check("midrst_bvalid", bvalid, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1; rdy = 1'b1; instr = {7'd0, 5'd9, 5'd9, 3'd0, 5'd0, 7'b0110011};
    step();
    check("midrst_reg", rd1, 0);
    check("midrst_pulses", pulses, 0);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      rdy      = ($urandom_range(0, 9) < 7);
      flush    = ($urandom_range(0, 9) == 0);
      instr    = rand_instr();
      pc       = $urandom;
      wb       = $urandom_range(0, 1);
      wb_addr  = 5'($urandom);
      wb_data  = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
      fwd_a    = ($urandom_range(0, 6) == 0);
      fwd_b    = ($urandom_range(0, 6) == 0);
      fdata_a  = $urandom;
      fdata_b  = $urandom;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
